// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and constants for the divided-clock ratio meter.
package clk_ratio_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   localparam int SYNC_STAGES = 2;

   // Bits needed to count 0..lock_count inclusive.
   function automatic int lock_cnt_width(input int lock_count);
      return $clog2(lock_count + 1);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer; resets to 0.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_sr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_sr <= '0;
      else          sync_sr <= {sync_sr[STAGES-2:0], i_d};
   end

   assign o_q = sync_sr[STAGES-1];

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period/high/low of a divided clock in i_ref_clk cycles and
// declares lock after LOCK_COUNT consecutive identical periods.
module clk_ratio_meter
   import clk_ratio_meter_pkg::*;
#(
   parameter int RATIO_WIDTH = 5,
   parameter int LOCK_COUNT  = 4
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_meas_en,
   input  logic                   i_div_clk,
   output logic [RATIO_WIDTH-1:0] o_ratio,
   output logic [RATIO_WIDTH-1:0] o_high_cnt,
   output logic [RATIO_WIDTH-1:0] o_low_cnt,
   output logic                   o_ratio_valid,
   output logic                   o_locked,
   output logic                   o_overflow
);

   localparam int                   LW        = lock_cnt_width(LOCK_COUNT);
   localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [LW-1:0]        LOCK_TGT  = LW'(LOCK_COUNT);
   localparam logic [LW-1:0]        LOCK_PRE  = LW'(LOCK_COUNT - 1);

   logic                   sync, sync_d, rise;
   state_t                 state, state_nxt;
   logic [RATIO_WIDTH-1:0] per_cnt, hi_cnt;
   logic [LW-1:0]          lock_cnt;
   logic                   first_meas;
   logic                   ovf_hit;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_ref_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_div_clk),
      .o_q     (sync)
   );

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_d <= 1'b0;
      else          sync_d <= sync;
   end

   assign rise    = sync & ~sync_d;
   // A rise coinciding with saturation is still a valid measurement.
   assign ovf_hit = (state == ST_MEAS) && !rise && (per_cnt == CNT_MAX);

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!i_meas_en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_ARM;
            ST_ARM:  if (rise) state_nxt = ST_MEAS;
            ST_MEAS: if (ovf_hit) state_nxt = ST_ARM;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         per_cnt       <= '0;
         hi_cnt        <= '0;
         lock_cnt      <= '0;
         first_meas    <= 1'b0;
         o_ratio       <= '0;
         o_high_cnt    <= '0;
         o_low_cnt     <= '0;
         o_ratio_valid <= 1'b0;
         o_locked      <= 1'b0;
         o_overflow    <= 1'b0;
      end else if (!i_meas_en) begin
         // Results are held; status and counters are cleared.
         per_cnt       <= '0;
         hi_cnt        <= '0;
         lock_cnt      <= '0;
         first_meas    <= 1'b0;
         o_ratio_valid <= 1'b0;
         o_locked      <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         o_ratio_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               per_cnt <= '0;
               hi_cnt  <= '0;
            end
            ST_ARM: begin
               first_meas <= 1'b1;
               if (rise) begin
                  per_cnt <= RATIO_WIDTH'(1);
                  hi_cnt  <= RATIO_WIDTH'(1);
               end
            end
            ST_MEAS: begin
               if (rise) begin
                  o_ratio       <= per_cnt;
                  o_high_cnt    <= hi_cnt;
                  o_low_cnt     <= per_cnt - hi_cnt;
                  o_ratio_valid <= 1'b1;
                  per_cnt       <= RATIO_WIDTH'(1);
                  hi_cnt        <= RATIO_WIDTH'(1);
                  first_meas    <= 1'b0;
                  if (first_meas || (per_cnt != o_ratio)) begin
                     lock_cnt <= LW'(1);
                     o_locked <= 1'b0;
                  end else begin
                     if (lock_cnt < LOCK_TGT) lock_cnt <= lock_cnt + 1'b1;
                     if (lock_cnt >= LOCK_PRE) o_locked <= 1'b1;
                  end
               end else if (ovf_hit) begin
                  o_overflow <= 1'b1;
                  o_locked   <= 1'b0;
                  lock_cnt   <= '0;
                  per_cnt    <= '0;
                  hi_cnt     <= '0;
               end else begin
                  per_cnt <= per_cnt + 1'b1;
                  hi_cnt  <= hi_cnt + RATIO_WIDTH'(sync);
               end
            end
            default: begin
               per_cnt <= '0;
               hi_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: vector table plus corner-case sequences.
module tb_clk_ratio_meter;

   localparam int RW = 5;
   localparam int LC = 4;

   logic          i_ref_clk = 1'b0;
   logic          i_rst_n   = 1'b1;
   logic          i_meas_en = 1'b0;
   logic          i_div_clk = 1'b0;
   logic [RW-1:0] o_ratio, o_high_cnt, o_low_cnt;
   logic          o_ratio_valid, o_locked, o_overflow;

   clk_ratio_meter #(.RATIO_WIDTH(RW), .LOCK_COUNT(LC)) dut (
      .i_ref_clk     (i_ref_clk),
      .i_rst_n       (i_rst_n),
      .i_meas_en     (i_meas_en),
      .i_div_clk     (i_div_clk),
      .o_ratio       (o_ratio),
      .o_high_cnt    (o_high_cnt),
      .o_low_cnt     (o_low_cnt),
      .o_ratio_valid (o_ratio_valid),
      .o_locked      (o_locked),
      .o_overflow    (o_overflow)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   // Divided-clock generator, updated on the falling reference edge.
   int gen_hi = 4, gen_lo = 4, gen_mode = 0, gen_phase = 0;
   int pend_hi = 4, pend_lo = 4;
   bit pend = 1'b0, load_now = 1'b0;

   initial begin
      forever begin
         @(negedge i_ref_clk);
         if (load_now) begin
            gen_hi = pend_hi; gen_lo = pend_lo; gen_mode = 0; gen_phase = 0;
            load_now = 1'b0;
         end else if (pend && gen_phase == 0) begin
            gen_hi = pend_hi; gen_lo = pend_lo; pend = 1'b0;
         end
         case (gen_mode)
            1:       i_div_clk = 1'b1;
            2:       i_div_clk = 1'b0;
            default: i_div_clk = (gen_phase < gen_hi);
         endcase
         gen_phase = (gen_phase + 1 >= gen_hi + gen_lo) ? 0 : gen_phase + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_ref_clk);
         if (o_ratio_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic setup(input int hi, input int lo);
      i_meas_en = 1'b0;
      @(negedge i_ref_clk);
      pend_hi  = hi;
      pend_lo  = lo;
      pend     = 1'b0;
      load_now = 1'b1;
      repeat (8) @(negedge i_ref_clk);
      i_meas_en = 1'b1;
   endtask

   typedef struct {
      int hi;
      int lo;
      int ratio;
      int high;
      int low;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit seen;
      int cnt;

      vecs[0] = '{hi: 4,  lo: 4,  ratio: 8,  high: 4,  low: 4};
      vecs[1] = '{hi: 2,  lo: 3,  ratio: 5,  high: 2,  low: 3};
      vecs[2] = '{hi: 1,  lo: 1,  ratio: 2,  high: 1,  low: 1};
      vecs[3] = '{hi: 3,  lo: 5,  ratio: 8,  high: 3,  low: 5};
      vecs[4] = '{hi: 10, lo: 21, ratio: 31, high: 10, low: 21};

      #2 i_rst_n = 1'b0;
      repeat (3) @(negedge i_ref_clk);
      chk("rst_ratio", o_ratio, 0);
      chk("rst_high", o_high_cnt, 0);
      chk("rst_low", o_low_cnt, 0);
      chk("rst_valid", o_ratio_valid, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_ovf", o_overflow, 0);
      i_rst_n = 1'b1;

      // Steady patterns: six measurements each, lock on the fourth.
      foreach (vecs[v]) begin
         setup(vecs[v].hi, vecs[v].lo);
         for (int k = 0; k < 6; k++) begin
            wait_valid(100, ok);
            chk($sformatf("v%0d_k%0d_valid", v, k), ok, 1);
            chk($sformatf("v%0d_k%0d_ratio", v, k), o_ratio, vecs[v].ratio);
            chk($sformatf("v%0d_k%0d_high", v, k), o_high_cnt, vecs[v].high);
            chk($sformatf("v%0d_k%0d_low", v, k), o_low_cnt, vecs[v].low);
            chk($sformatf("v%0d_k%0d_locked", v, k), o_locked, (k >= 3) ? 1 : 0);
            chk($sformatf("v%0d_k%0d_ovf", v, k), o_overflow, 0);
         end
      end

      // Locked at 8, switch to 6 at the next period boundary.
      setup(4, 4);
      for (int k = 0; k < 4; k++) wait_valid(100, ok);
      chk("sw_pre_locked", o_locked, 1);
      pend_hi = 3; pend_lo = 3; pend = 1'b1;
      wait_valid(100, ok);
      chk("sw_last8_ratio", o_ratio, 8);
      chk("sw_last8_locked", o_locked, 1);
      wait_valid(100, ok);
      chk("sw_first6_valid", ok, 1);
      chk("sw_first6_ratio", o_ratio, 6);
      chk("sw_first6_locked", o_locked, 0);
      for (int k = 0; k < 2; k++) begin
         wait_valid(100, ok);
         chk($sformatf("sw_6_%0d_locked", k), o_locked, 0);
      end
      wait_valid(100, ok);
      chk("sw_relock_ratio", o_ratio, 6);
      chk("sw_relock_high", o_high_cnt, 3);
      chk("sw_relock_locked", o_locked, 1);

      // Stuck high after lock: overflow 31 cycles after last valid.
      setup(4, 4);
      for (int k = 0; k < 4; k++) wait_valid(100, ok);
      chk("stk_pre_locked", o_locked, 1);
      gen_mode = 1;
      cnt = 0;
      while (!o_overflow && cnt < 60) begin
         @(negedge i_ref_clk);
         cnt++;
      end
      chk("stk_ovf_delay", cnt, 31);
      chk("stk_ovf", o_overflow, 1);
      chk("stk_locked", o_locked, 0);
      chk("stk_ratio_hold", o_ratio, 8);
      pend_hi = 4; pend_lo = 4; load_now = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_valid(100, ok);
         chk($sformatf("stk_rearm_valid%0d", k), ok, 1);
      end
      chk("stk_rearm_ovf_sticky", o_overflow, 1);
      chk("stk_rearm_ratio", o_ratio, 8);
      i_meas_en = 1'b0;
      repeat (2) @(negedge i_ref_clk);
      chk("stk_dis_ovf", o_overflow, 0);
      chk("stk_dis_locked", o_locked, 0);
      chk("stk_dis_ratio", o_ratio, 8);

      // Period 32 never produces a measurement, only overflow.
      setup(16, 16);
      seen = 1'b0;
      cnt = 0;
      while (!o_overflow && cnt < 120) begin
         @(negedge i_ref_clk);
         if (o_ratio_valid) seen = 1'b1;
         cnt++;
      end
      chk("p32_ovf", o_overflow, 1);
      chk("p32_no_valid", seen, 0);
      chk("p32_locked", o_locked, 0);

      // Enable dropped mid-measurement: results held, no further pulses.
      setup(2, 3);
      for (int k = 0; k < 2; k++) wait_valid(100, ok);
      repeat (2) @(negedge i_ref_clk);
      i_meas_en = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge i_ref_clk);
         if (o_ratio_valid) seen = 1'b1;
      end
      chk("dis_no_valid", seen, 0);
      chk("dis_ratio", o_ratio, 5);
      chk("dis_high", o_high_cnt, 2);
      chk("dis_low", o_low_cnt, 3);
      chk("dis_ovf", o_overflow, 0);

      // Asynchronous reset mid-measurement.
      setup(4, 4);
      for (int k = 0; k < 4; k++) wait_valid(100, ok);
      repeat (2) @(negedge i_ref_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst_ratio", o_ratio, 0);
      chk("arst_high", o_high_cnt, 0);
      chk("arst_locked", o_locked, 0);
      @(negedge i_ref_clk);
      i_rst_n = 1'b1;
      wait_valid(100, ok);
      chk("arst_first_valid", ok, 1);
      chk("arst_first_ratio", o_ratio, 8);
      chk("arst_first_locked", o_locked, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
